// File: rtl/mult_sat_seq.sv
// Sequential shift-add signed fixed-point multiplier with saturation to Q(Width-Frac).Frac.
// Define MULT_SAT_SEQ_ROUND_EN to round half away from zero instead of truncating.
module mult_sat_seq #(
    parameter int Width = 12,
    parameter int Frac  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    output logic [Width-1:0] Y,
    output logic             done,
    output logic             busy
);
    localparam int MW = Width + 1;
    localparam int AW = 2 * Width + 2;
    localparam int CW = $clog2(Width + 2);
    localparam logic [AW:0] POS_MAX = (AW+1)'(2**(Width-1) - 1);
    localparam logic [AW:0] NEG_MAG = (AW+1)'(2**(Width-1));

    typedef enum logic [1:0] {IDLE, OP, ADJ, DONE} state_t;

    state_t          state_q, state_d;
    logic [MW-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]   mcand_q, mcand_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sign_q, sign_d;
    logic [Width-1:0] y_q, y_d;

    // One extra bit keeps |-2^(Width-1)| representable.
    logic [MW-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic [AW:0]     rnd_mag, scaled;
    logic [Width-1:0] y_sat;

    assign a_ext = {A[Width-1], A};
    assign b_ext = {B[Width-1], B};
    assign a_mag = A[Width-1] ? -a_ext : a_ext;
    assign b_mag = B[Width-1] ? -b_ext : b_ext;

`ifdef MULT_SAT_SEQ_ROUND_EN
    localparam int          HALF_SH = (Frac > 0) ? Frac - 1 : 0;
    localparam logic [AW:0] HALF    = (Frac > 0) ? ((AW+1)'(1) << HALF_SH) : '0;
    assign rnd_mag = {1'b0, acc_q} + HALF;
`else
    assign rnd_mag = {1'b0, acc_q};
`endif
    assign scaled = rnd_mag >> Frac;

    // Zero magnitude negates to zero, so no -0 can appear.
    always_comb begin
        y_sat = '0;
        if (!sign_q) begin
            y_sat = (scaled > POS_MAX) ? {1'b0, {(Width-1){1'b1}}} : scaled[Width-1:0];
        end else begin
            y_sat = (scaled > NEG_MAG) ? {1'b1, {(Width-1){1'b0}}} : -scaled[Width-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            y_q      <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = OP;
            OP:      if (cnt_q == '0) state_d = ADJ;
            ADJ:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        y_d      = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{(AW-MW){1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CW'(MW);
                    sign_d   = A[Width-1] ^ B[Width-1];
                end
            end
            OP: begin
                if (cnt_q != '0) begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            ADJ:     y_d = y_sat;
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    assign Y = y_q;
endmodule

// File: tb/tb_mult_sat_seq.sv
// Directed bench for mult_sat_seq (Width=12, Frac=8): results, saturation, latency, reset abort, back-to-back.
module tb_mult_sat_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] A, B;
    logic [11:0] Y;
    logic        done, busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

`ifdef MULT_SAT_SEQ_ROUND_EN
    localparam logic [11:0] EXP_SMALL_POS = 12'h001;
    localparam logic [11:0] EXP_SMALL_NEG = 12'hFFF;
`else
    localparam logic [11:0] EXP_SMALL_POS = 12'h000;
    localparam logic [11:0] EXP_SMALL_NEG = 12'h000;
`endif

    mult_sat_seq #(.Width(12), .Frac(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .A(A), .B(B), .Y(Y), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] y_exp, input string tag);
        int t0;
        bit busy_ok;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0 = cyc;
        busy_ok = 1'b1;
        while (!done && (cyc - t0) < 40) begin
            @(negedge clk);
            if (!done && !busy) busy_ok = 1'b0;
        end
        $display("op %s: A=%03h B=%03h Y=%03h after %0d edges", tag, a, b, Y, cyc - t0);
        check(cyc - t0, 15, {tag, " latency"});
        check({20'd0, Y}, {20'd0, y_exp}, {tag, " Y"});
        check({31'd0, busy_ok}, 1, {tag, " busy"});
        @(negedge clk);
        check({31'd0, done}, 0, {tag, " done width"});
        repeat (3) @(negedge clk);
        check({20'd0, Y}, {20'd0, y_exp}, {tag, " Y hold"});
    endtask

    initial begin : stim
        int t0;
        int td [3];
        bit saw_done;
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        $display("reset: Y=%03h done=%0b busy=%0b", Y, done, busy);
        check({20'd0, Y}, 0, "reset Y");
        check({31'd0, done}, 0, "reset done");
        check({31'd0, busy}, 0, "reset busy");
        reset = 1'b0;

        run_op(12'h100, 12'h180, 12'h180, "1.0*1.5");
        run_op(12'hF00, 12'h200, 12'hE00, "-1.0*2.0");
        run_op(12'h7FF, 12'h7FF, 12'h7FF, "possat");
        run_op(12'h800, 12'h800, 12'h7FF, "min*min");
        run_op(12'h800, 12'h7FF, 12'h800, "negsat");
        run_op(12'h001, 12'h080, EXP_SMALL_POS, "small pos");
        run_op(12'hFFF, 12'h080, EXP_SMALL_NEG, "small neg");
        run_op(12'h000, 12'h900, 12'h000, "zero*neg");

        // Reset during OP iteration 5; Y carries a nonzero value beforehand.
        run_op(12'h100, 12'h180, 12'h180, "pre-abort");
        @(negedge clk);
        A = 12'h7FF; B = 12'h7FF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        $display("abort: Y=%03h done=%0b busy=%0b", Y, done, busy);
        check({20'd0, Y}, 0, "abort Y");
        check({31'd0, busy}, 0, "abort busy");
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check({31'd0, saw_done}, 0, "abort no done");
        reset = 1'b0;
        run_op(12'hF00, 12'h200, 12'hE00, "after reset");

        // Start held high for three operations.
        @(negedge clk);
        A = 12'h100; B = 12'h180; start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        for (int k = 0; k < 3; k++) begin
            while (!done && (cyc - t0) < 200) @(negedge clk);
            td[k] = cyc - t0;
            if (k == 2) start = 1'b0;
            $display("b2b %0d: done at edge %0d Y=%03h", k, td[k], Y);
            check({20'd0, Y}, 12'h180, "b2b Y");
            @(negedge clk);
        end
        check(td[0], 15, "b2b done0");
        check(td[1], 32, "b2b done1");
        check(td[2], 49, "b2b done2");
        repeat (2) @(negedge clk);
        check({31'd0, busy}, 0, "b2b stop");

        // Start pulse while busy must be ignored and not queued.
        @(negedge clk);
        A = 12'h100; B = 12'h200; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
        repeat (4) @(negedge clk);
        A = 12'h7FF; B = 12'h7FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && (cyc - t0) < 40) @(negedge clk);
        $display("busy start: done at edge %0d Y=%03h", cyc - t0, Y);
        check(cyc - t0, 15, "busy start latency");
        check({20'd0, Y}, 12'h200, "busy start Y");
        repeat (3) @(negedge clk);
        check({31'd0, busy}, 0, "busy start not queued");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
